// File: rtl/window_accumulator.sv
// Windowed signed accumulator with saturation; presents each window total
// on a valid/ready output as one decision-tree feature.
module window_accumulator #(
   parameter int IN_WIDTH  = 8,
   parameter int ACC_WIDTH = 12,
   parameter int WINDOW    = 16,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 clear,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [IN_WIDTH-1:0]  sample,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_WIDTH-1:0] sum,
   output logic                 sat,
   output logic [CNT_WIDTH-1:0] count
);

   typedef enum logic {ACCUM, HOLD} state_t;

   localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
   localparam logic [CNT_WIDTH-1:0] LAST    = CNT_WIDTH'(WINDOW - 1);

   state_t               state;
   logic [ACC_WIDTH-1:0] acc;
   logic [ACC_WIDTH-1:0] ext;
   logic [ACC_WIDTH:0]   wide;
   logic                 ovf;
   logic [ACC_WIDTH-1:0] next_acc;
   logic                 accept;
   logic                 xfer;

   assign in_ready  = (state == ACCUM);
   assign out_valid = (state == HOLD);
   assign accept    = in_valid & in_ready;
   assign xfer      = out_valid & out_ready;

   // Top two bits of the widened sum disagree exactly on signed overflow;
   // the widened MSB is the true sign and picks the clamp direction.
   assign ext      = {{(ACC_WIDTH-IN_WIDTH){sample[IN_WIDTH-1]}}, sample};
   assign wide     = {acc[ACC_WIDTH-1], acc} + {ext[ACC_WIDTH-1], ext};
   assign ovf      = wide[ACC_WIDTH] ^ wide[ACC_WIDTH-1];
   assign next_acc = ovf ? (wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX)
                         : wide[ACC_WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ACCUM;
         acc   <= '0;
         count <= '0;
         sat   <= 1'b0;
         sum   <= '0;
      end else if (clear) begin
         state <= ACCUM;
         acc   <= '0;
         count <= '0;
         sat   <= 1'b0;
      end else begin
         unique case (state)
            ACCUM: begin
               if (accept) begin
                  sat <= sat | ovf;
                  if (count == LAST) begin
                     sum   <= next_acc;
                     acc   <= '0;
                     count <= '0;
                     state <= HOLD;
                  end else begin
                     acc   <= next_acc;
                     count <= count + CNT_WIDTH'(1);
                  end
               end
            end
            HOLD: begin
               if (xfer) begin
                  state <= ACCUM;
                  sat   <= 1'b0;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

endmodule

// File: tb/tb_window_accumulator.sv
// Directed plus randomized bench for window_accumulator against an
// integer running-clamp model of each window.
module tb_window_accumulator;

   localparam int IW   = 8;
   localparam int AW   = 10;
   localparam int WIN  = 16;
   localparam int CW   = 16;
   localparam int AMAX = (1 << (AW - 1)) - 1;
   localparam int AMIN = -(1 << (AW - 1));

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clear = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [IW-1:0] sample = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [AW-1:0] sum;
   logic          sat;
   logic [CW-1:0] count;

   int checks = 0;
   int failures = 0;
   int win [WIN];

   window_accumulator #(
      .IN_WIDTH(IW), .ACC_WIDTH(AW), .WINDOW(WIN), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready), .sample(sample),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .sat(sat), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int ssum();
      return int'($signed(sum));
   endfunction

   // Running total clamped to the accumulator range after every sample.
   task automatic model(output int s, output int st);
      s = 0;
      st = 0;
      for (int i = 0; i < WIN; i++) begin
         s += win[i];
         if (s > AMAX) begin s = AMAX; st = 1; end
         else if (s < AMIN) begin s = AMIN; st = 1; end
      end
   endtask

   task automatic fill_const(input int v);
      for (int i = 0; i < WIN; i++) win[i] = v;
   endtask

   task automatic fill_rand(input int mode);
      for (int i = 0; i < WIN; i++) begin
         case (mode)
            0: win[i] = int'($urandom_range(0, 255)) - 128;
            1: win[i] = int'($urandom_range(60, 127));
            default: win[i] = -int'($urandom_range(60, 128));
         endcase
      end
   endtask

   task automatic feed(input int n, input bit gaps);
      for (int i = 0; i < n; i++) begin
         if (gaps && ($urandom_range(0, 3) == 0)) begin
            in_valid = 1'b0;
            sample = IW'($urandom);
            tick();
            chk("gap_count", int'(count), i);
         end
         in_valid = 1'b1;
         sample = IW'(win[i]);
         chk("feed_ready", int'(in_ready), 1);
         chk("feed_count", int'(count), i);
         tick();
      end
      in_valid = 1'b0;
   endtask

   task automatic finish(input int hold);
      int es;
      int est;
      model(es, est);
      chk("res_valid", int'(out_valid), 1);
      chk("res_sum", ssum(), es);
      chk("res_sat", int'(sat), est);
      chk("res_ready", int'(in_ready), 0);
      chk("res_count", int'(count), 0);
      for (int h = 0; h < hold; h++) begin
         out_ready = 1'b0;
         in_valid = 1'b1;
         sample = IW'($urandom);
         tick();
         chk("hold_valid", int'(out_valid), 1);
         chk("hold_sum", ssum(), es);
         chk("hold_sat", int'(sat), est);
         chk("hold_count", int'(count), 0);
         chk("hold_ready", int'(in_ready), 0);
      end
      out_ready = 1'b1;
      in_valid = 1'b1;
      sample = 8'd5;
      tick();
      in_valid = 1'b0;
      chk("xfer_valid", int'(out_valid), 0);
      chk("xfer_ready", int'(in_ready), 1);
      chk("xfer_sat", int'(sat), 0);
      chk("xfer_count", int'(count), 0);
   endtask

   initial begin
      int es;
      int est;
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      chk("rst_ready", int'(in_ready), 1);
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_count", int'(count), 0);
      chk("rst_sum", ssum(), 0);
      chk("rst_sat", int'(sat), 0);

      out_ready = 1'b1;
      fill_const(3);
      feed(WIN, 1'b0);
      chk("p3_sum", ssum(), 48);
      finish(0);

      for (int i = 0; i < WIN; i++) win[i] = (i % 2 == 0) ? -128 : 127;
      feed(WIN, 1'b0);
      chk("alt_sum", ssum(), -8);
      finish(0);

      fill_const(-1);
      feed(WIN, 1'b0);
      chk("m1_sum", ssum(), -16);
      finish(0);

      fill_const(127);
      feed(WIN, 1'b0);
      chk("sat_sum", ssum(), AMAX);
      chk("sat_flag", int'(sat), 1);
      finish(0);

      fill_const(0);
      feed(WIN, 1'b0);
      chk("zero_sum", ssum(), 0);
      finish(0);

      fill_rand(0);
      feed(WIN, 1'b0);
      finish(5);

      // clear partway through a window
      fill_const(7);
      feed(9, 1'b0);
      chk("pre_clr_count", int'(count), 9);
      clear = 1'b1;
      in_valid = 1'b1;
      tick();
      clear = 1'b0;
      in_valid = 1'b0;
      chk("clr_count", int'(count), 0);
      chk("clr_valid", int'(out_valid), 0);
      chk("clr_ready", int'(in_ready), 1);

      // clear in HOLD beats a simultaneous transfer
      fill_const(127);
      feed(WIN, 1'b0);
      chk("clrh_valid0", int'(out_valid), 1);
      clear = 1'b1;
      out_ready = 1'b1;
      tick();
      clear = 1'b0;
      chk("clrh_valid", int'(out_valid), 0);
      chk("clrh_count", int'(count), 0);
      chk("clrh_sat", int'(sat), 0);
      chk("clrh_ready", int'(in_ready), 1);

      fill_const(1);
      feed(WIN, 1'b0);
      chk("one_sum", ssum(), 16);
      finish(0);

      // reset mid-window
      fill_const(9);
      feed(5, 1'b0);
      rst_n = 1'b0;
      in_valid = 1'b1;
      tick();
      rst_n = 1'b1;
      in_valid = 1'b0;
      chk("mrst_count", int'(count), 0);
      chk("mrst_valid", int'(out_valid), 0);
      chk("mrst_ready", int'(in_ready), 1);
      chk("mrst_sum", ssum(), 0);
      chk("mrst_sat", int'(sat), 0);

      fill_const(2);
      feed(WIN, 1'b0);
      chk("two_sum", ssum(), 32);
      finish(0);

      for (int r = 0; r < 12; r++) begin
         fill_rand(r % 3);
         feed(WIN, 1'b1);
         model(es, est);
         chk("rnd_sum", ssum(), es);
         finish(int'($urandom_range(0, 3)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
